// File: rtl/debounce_fsm_if.sv
// Button path bundle between the raw button source and the debounce stage.
// The master drives the raw button level; the slave returns the clean level
// and the one-cycle press pulse.
interface debounce_fsm_if;
  logic in;        // raw button, asynchronous to clk, may bounce
  logic db_level;  // debounced level
  logic db_tick;   // one-cycle pulse on each confirmed press

  modport master (
    output in,
    input  db_level,
    input  db_tick
  );

  modport slave (
    input  in,
    output db_level,
    output db_tick
  );
endinterface

// File: rtl/debounce_fsm.sv
// Push-button debouncer. The raw button is brought into the clk domain by a
// two-flop synchronizer, and every level change has to stay stable for three
// consecutive ticks (one tick = 2^N clk cycles) before the clean level follows.
// A single-cycle pulse marks each confirmed press; releases never pulse.
module debounce_fsm #(
  parameter int unsigned N = 20
) (
  input  logic           clk,
  input  logic           reset,
  debounce_fsm_if.slave  bus
);

  // ZERO has a fixed encoding so the idle state is easy to spot in waveforms.
  typedef enum logic [2:0] {
    StZero  = 3'd0,
    StWait11 = 3'd1,
    StWait12 = 3'd2,
    StWait13 = 3'd3,
    StOne   = 3'd4,
    StWait01 = 3'd5,
    StWait02 = 3'd6,
    StWait03 = 3'd7
  } state_e;

  logic [1:0]   sync_q;
  logic         s;
  state_e       state_q;
  logic [N-1:0] timer_q;
  logic         tick;
  logic         db_level_q;
  logic         db_tick_q;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.in};
    end
  end

  assign s = sync_q[1];

  // Tick fires on the last count of the timer; it wraps on the same edge.
  assign tick = (timer_q == {N{1'b1}});

  // Qualification FSM with its timer and registered outputs. A revert of s
  // is tested before tick, so a bounce on the tick cycle still aborts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StZero;
      timer_q    <= '0;
      db_level_q <= 1'b0;
      db_tick_q  <= 1'b0;
    end else begin
      db_tick_q <= 1'b0;
      unique case (state_q)
        StZero: begin
          timer_q <= '0;
          if (s) begin
            state_q <= StWait11;
          end
        end
        StWait11: begin
          if (!s) begin
            state_q <= StZero;
            timer_q <= '0;
          end else if (tick) begin
            state_q <= StWait12;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + N'(1);
          end
        end
        StWait12: begin
          if (!s) begin
            state_q <= StZero;
            timer_q <= '0;
          end else if (tick) begin
            state_q <= StWait13;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + N'(1);
          end
        end
        StWait13: begin
          if (!s) begin
            state_q <= StZero;
            timer_q <= '0;
          end else if (tick) begin
            state_q    <= StOne;
            timer_q    <= '0;
            db_level_q <= 1'b1;
            db_tick_q  <= 1'b1;
          end else begin
            timer_q <= timer_q + N'(1);
          end
        end
        StOne: begin
          timer_q <= '0;
          if (!s) begin
            state_q <= StWait01;
          end
        end
        StWait01: begin
          if (s) begin
            state_q <= StOne;
            timer_q <= '0;
          end else if (tick) begin
            state_q <= StWait02;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + N'(1);
          end
        end
        StWait02: begin
          if (s) begin
            state_q <= StOne;
            timer_q <= '0;
          end else if (tick) begin
            state_q <= StWait03;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + N'(1);
          end
        end
        StWait03: begin
          if (s) begin
            state_q <= StOne;
            timer_q <= '0;
          end else if (tick) begin
            state_q    <= StZero;
            timer_q    <= '0;
            db_level_q <= 1'b0;
          end else begin
            timer_q <= timer_q + N'(1);
          end
        end
        default: begin
          state_q    <= StZero;
          timer_q    <= '0;
          db_level_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.db_level = db_level_q;
  assign bus.db_tick  = db_tick_q;

  // The clean level tracks the "pressed" half of the state space.
  a_level_matches_state: assert property (@(posedge clk) disable iff (reset)
    db_level_q == (state_q inside {StOne, StWait01, StWait02, StWait03}));

  // A press pulse only ever accompanies a high level.
  a_tick_implies_level: assert property (@(posedge clk) disable iff (reset)
    db_tick_q |-> db_level_q);

  // The timer rests at zero in the two settled states.
  a_timer_idle: assert property (@(posedge clk) disable iff (reset)
    (state_q inside {StZero, StOne}) |-> (timer_q == '0));

endmodule
